// File: rtl/ctrl_issue_de_if.sv
// D->E control boundary bundle: decode-side inputs, registered E-stage control outputs, squash status.
// Latency: n/a (wiring only).
// Backpressure: StallE holds the E register; FlushE/BranchTakenE force bubbles.
interface ctrl_issue_de_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      InstrD;
    logic             ValidD;
    logic             StallE;
    logic             FlushE;
    logic             BranchTakenE;
    logic [3:0]       CondE;
    logic [1:0]       FlagWriteE;
    logic             RegWriteE;
    logic             MemWriteE;
    logic             MemtoRegE;
    logic             BranchE;
    logic [1:0]       ALUControlE;
    logic             FlushD;
    logic             Squashing;
    logic [CNT_W-1:0] SquashCount;

    modport master (
        output InstrD, ValidD, StallE, FlushE, BranchTakenE,
        input  CondE, FlagWriteE, RegWriteE, MemWriteE, MemtoRegE, BranchE,
        input  ALUControlE, FlushD, Squashing, SquashCount
    );

    modport slave (
        input  InstrD, ValidD, StallE, FlushE, BranchTakenE,
        output CondE, FlagWriteE, RegWriteE, MemWriteE, MemtoRegE, BranchE,
        output ALUControlE, FlushD, Squashing, SquashCount
    );
endinterface

// File: rtl/ctrl_issue_de.sv
// Decode-side control cracker feeding E, plus taken-branch squash FSM (optional SQUASH_PERF_EN counter).
// Latency: 1 cycle D->E; FlushD is combinational from BranchTakenE and the squash state.
// Backpressure: StallE holds E bit-exact; any flush/squash bubble overrides the stall.
module ctrl_issue_de #(
    parameter int SQUASH_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input logic           CLK,
    input logic           Reset,
    ctrl_issue_de_if.slave de
);
    typedef struct packed {
        logic [3:0] cond;
        logic [1:0] flag_write;
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic [1:0] alu_ctrl;
    } e_ctrl_t;

    typedef enum logic {IDLE, SQUASH} state_t;

    localparam e_ctrl_t    BUBBLE   = '{cond: 4'b1110, default: '0};
    localparam logic [2:0] CNT_INIT = 3'(SQUASH_CYCLES - 1);

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic       s_bit;
    logic       is_cmp;
    logic       dp_ok;
    logic [1:0] alu_sel;
    logic       unused_bits;
    e_ctrl_t    dec;
    e_ctrl_t    e_q;
    state_t     state;
    logic [2:0] sq_cnt;
    logic       squashing_q;

    assign cond        = de.InstrD[31:28];
    assign op          = de.InstrD[27:26];
    assign funct       = de.InstrD[25:20];
    assign cmd         = funct[4:1];
    assign s_bit       = funct[0];
    assign is_cmp      = (cmd == CMD_CMP);
    assign unused_bits = ^de.InstrD[19:0];

    always_comb begin
        alu_sel = 2'b00;
        dp_ok   = 1'b0;
        case (cmd)
            CMD_ADD: begin alu_sel = 2'b00; dp_ok = 1'b1; end
            CMD_SUB: begin alu_sel = 2'b01; dp_ok = 1'b1; end
            CMD_AND: begin alu_sel = 2'b10; dp_ok = 1'b1; end
            CMD_ORR: begin alu_sel = 2'b11; dp_ok = 1'b1; end
            CMD_CMP: begin alu_sel = 2'b01; dp_ok = 1'b1; end
            default: ;
        endcase
    end

    // Anything not explicitly decoded (invalid slot, Op=11, unknown cmd) stays a bubble.
    always_comb begin
        dec = BUBBLE;
        if (de.ValidD) begin
            case (op)
                2'b00: if (dp_ok) begin
                    dec.cond       = cond;
                    dec.alu_ctrl   = alu_sel;
                    dec.reg_write  = ~is_cmp;
                    dec.flag_write = {s_bit | is_cmp,
                                      (s_bit & ((cmd == CMD_ADD) | (cmd == CMD_SUB))) | is_cmp};
                end
                2'b01: begin
                    dec.cond       = cond;
                    dec.reg_write  = funct[0];
                    dec.mem_to_reg = funct[0];
                    dec.mem_write  = ~funct[0];
                end
                2'b10: begin
                    dec.cond   = cond;
                    dec.branch = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            e_q         <= BUBBLE;
            state       <= IDLE;
            sq_cnt      <= 3'd0;
            squashing_q <= 1'b0;
        end else begin
            if (de.FlushE || (state != IDLE) || de.BranchTakenE) begin
                e_q <= BUBBLE;
            end else if (!de.StallE) begin
                e_q <= dec;
            end

            // The squash window runs on its own clock count; StallE does not extend it.
            case (state)
                IDLE: if (de.BranchTakenE) begin
                    state       <= SQUASH;
                    squashing_q <= 1'b1;
                    sq_cnt      <= CNT_INIT;
                end
                SQUASH: if (sq_cnt == 3'd0) begin
                    state       <= IDLE;
                    squashing_q <= 1'b0;
                end else begin
                    sq_cnt <= sq_cnt - 3'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SQUASH_PERF_EN
    logic [CNT_W-1:0] perf_cnt;

    // FlushE-only bubbles are hazard-unit traffic, not branch cost, so they are excluded.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            perf_cnt <= '0;
        end else if ((de.BranchTakenE || (state == SQUASH)) && (perf_cnt != {CNT_W{1'b1}})) begin
            perf_cnt <= perf_cnt + 1'b1;
        end
    end

    assign de.SquashCount = perf_cnt;
`else
    assign de.SquashCount = {CNT_W{1'b0}};
`endif

    assign de.CondE       = e_q.cond;
    assign de.FlagWriteE  = e_q.flag_write;
    assign de.RegWriteE   = e_q.reg_write;
    assign de.MemWriteE   = e_q.mem_write;
    assign de.MemtoRegE   = e_q.mem_to_reg;
    assign de.BranchE     = e_q.branch;
    assign de.ALUControlE = e_q.alu_ctrl;
    assign de.FlushD      = de.BranchTakenE | (state == SQUASH);
    assign de.Squashing   = squashing_q;
endmodule

// File: tb/tb_ctrl_issue_de.sv
// Bench for ctrl_issue_de: decode vector table, stall/flush priority, branch squash, reset mid-squash.
module tb_ctrl_issue_de;
    localparam int CNT_W = 16;

    // Packed E view: {cond[3:0], flag_write[1:0], reg_write, mem_write, mem_to_reg, branch, alu[1:0]}
    localparam logic [11:0] BUB   = 12'b1110_00_0_0_0_0_00;
    localparam logic [11:0] ADDS  = 12'b1110_11_1_0_0_0_00;
    localparam logic [11:0] ADD   = 12'b1110_00_1_0_0_0_00;
    localparam logic [11:0] CMP   = 12'b1110_11_0_0_0_0_01;
    localparam logic [11:0] LDR   = 12'b1110_00_1_0_1_0_00;
    localparam logic [11:0] STR   = 12'b1110_00_0_1_0_0_00;
    localparam logic [11:0] BEQ   = 12'b0000_00_0_0_0_1_00;
    localparam logic [11:0] SUB   = 12'b1110_00_1_0_0_0_01;
    localparam logic [11:0] SUBS  = 12'b1110_11_1_0_0_0_01;
    localparam logic [11:0] ANDS  = 12'b1110_10_1_0_0_0_10;
    localparam logic [11:0] ORR   = 12'b1110_00_1_0_0_0_11;
    localparam logic [11:0] ORRS  = 12'b1110_10_1_0_0_0_11;
    localparam logic [11:0] CMP0  = 12'b0000_11_0_0_0_0_01;
    localparam logic [11:0] ADDS1 = 12'b0001_11_1_0_0_0_00;

    localparam logic [31:0] I_ADDS = 32'hE0921003;
    localparam logic [31:0] I_CMP  = 32'hE1510002;
    localparam logic [31:0] I_LDR  = 32'hE5912000;
    localparam logic [31:0] I_BEQ  = 32'h0A000001;

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        stall;
        logic        flush;
        logic        hold;
        logic [11:0] exp_e;
        string       name;
    } vec_t;

    typedef struct {
        logic [11:0]      e;
        logic             sq;
        logic             fd;
        logic [CNT_W-1:0] perf;
        string            name;
    } sb_t;

    logic CLK = 1'b0;
    logic Reset;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [CNT_W-1:0] exp_perf = '0;
    vec_t vt[$];
    sb_t  sbq[$];

    ctrl_issue_de_if #(.CNT_W(CNT_W)) bus ();

    ctrl_issue_de #(.SQUASH_CYCLES(2), .CNT_W(CNT_W)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .de    (bus)
    );

    always #5 CLK = ~CLK;

    function automatic logic [11:0] e_act();
        return {bus.CondE, bus.FlagWriteE, bus.RegWriteE, bus.MemWriteE,
                bus.MemtoRegE, bus.BranchE, bus.ALUControlE};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [31:0] instr, input logic valid, stall, flush, hold,
                           input logic [11:0] exp_e, input string name);
        vec_t v;
        v.instr = instr; v.valid = valid; v.stall = stall; v.flush = flush;
        v.hold = hold; v.exp_e = exp_e; v.name = name;
        vt.push_back(v);
    endtask

    // Drive one cycle, check the combinational FlushD before the edge, then score E after it.
    task automatic step(input logic [31:0] instr, input logic valid, stall, flush, bt, rst,
                        input logic [11:0] exp_e, input logic exp_sq, input logic fd_pre,
                        input int perf_inc, input string name);
        sb_t s;
        sb_t got;
        @(negedge CLK);
        bus.InstrD = instr; bus.ValidD = valid; bus.StallE = stall;
        bus.FlushE = flush; bus.BranchTakenE = bt; Reset = rst;
`ifdef SQUASH_PERF_EN
        if (rst) exp_perf = '0;
        else     exp_perf = exp_perf + CNT_W'(perf_inc);
`endif
        s.e = exp_e; s.sq = exp_sq; s.fd = bt | exp_sq; s.perf = exp_perf; s.name = name;
        sbq.push_back(s);
        #1;
        check({name, ".flushd_pre"}, 32'(bus.FlushD), 32'(fd_pre));
        @(posedge CLK);
        #1;
        got = sbq.pop_front();
        check({got.name, ".e"},         32'(e_act()),         32'(got.e));
        check({got.name, ".squashing"}, 32'(bus.Squashing),   32'(got.sq));
        check({got.name, ".flushd"},    32'(bus.FlushD),      32'(got.fd));
        check({got.name, ".count"},     32'(bus.SquashCount), 32'(got.perf));
    endtask

    initial begin
        logic [11:0] last_e;

        bus.InstrD = '0; bus.ValidD = 1'b0; bus.StallE = 1'b0;
        bus.FlushE = 1'b0; bus.BranchTakenE = 1'b0; Reset = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("reset.e",         32'(e_act()),         32'(BUB));
        check("reset.flushd",    32'(bus.FlushD),      32'd0);
        check("reset.squashing", 32'(bus.Squashing),   32'd0);
        check("reset.count",     32'(bus.SquashCount), 32'd0);

        //       instr          vld stl fl  hold exp   name
        add_vec(I_ADDS,         1, 0, 0, 0, ADDS,  "adds");
        add_vec(I_CMP,          1, 1, 0, 1, BUB,   "stall_hold");
        add_vec(I_CMP,          1, 1, 1, 0, BUB,   "stall_flush");
        add_vec(I_ADDS,         1, 0, 1, 0, BUB,   "flush");
        add_vec(I_CMP,          1, 0, 0, 0, CMP,   "cmp");
        add_vec(I_LDR,          1, 0, 0, 0, LDR,   "ldr");
        add_vec(32'hE5812000,   1, 0, 0, 0, STR,   "str");
        add_vec(I_BEQ,          1, 0, 0, 0, BEQ,   "beq");
        add_vec(32'hE0421003,   1, 0, 0, 0, SUB,   "sub");
        add_vec(32'hE0521003,   1, 0, 0, 0, SUBS,  "subs");
        add_vec(32'hE0121003,   1, 0, 0, 0, ANDS,  "ands");
        add_vec(32'hE1821003,   1, 0, 0, 0, ORR,   "orr");
        add_vec(32'hE1921003,   1, 0, 0, 0, ORRS,  "orrs");
        add_vec(32'hE0221003,   1, 0, 0, 0, BUB,   "eor_illegal");
        add_vec(32'hEC000000,   1, 0, 0, 0, BUB,   "op11");
        add_vec(I_ADDS,         0, 0, 0, 0, BUB,   "invalid");
        add_vec(32'h01510002,   1, 0, 0, 0, CMP0,  "cmp_cond0");
        add_vec(32'h10921003,   1, 0, 0, 0, ADDS1, "adds_cond1");
        add_vec(32'hE1410002,   1, 0, 0, 0, CMP,   "cmp_nos");
        add_vec(32'hE0821003,   1, 0, 0, 0, ADD,   "add_nos");
        add_vec(I_LDR,          1, 1, 0, 1, BUB,   "stall_hold2");
        add_vec(I_BEQ,          0, 0, 0, 0, BUB,   "invalid_b");

        last_e = BUB;
        for (int i = 0; i < vt.size(); i++) begin
            logic [11:0] e;
            e = vt[i].hold ? last_e : vt[i].exp_e;
            step(vt[i].instr, vt[i].valid, vt[i].stall, vt[i].flush, 1'b0, 1'b0,
                 e, 1'b0, 1'b0, 0, vt[i].name);
            last_e = e;
        end

        // Taken branch: one bubble on the taken edge, then SQUASH_CYCLES squash-state bubbles.
        //   instr   v  st fl bt rst exp   sq fd_pre inc
        step(I_BEQ,  1, 0, 0, 0, 0, BEQ,  0, 0, 0, "br.load");
        step(I_ADDS, 1, 0, 0, 1, 0, BUB,  1, 1, 1, "br.taken");
        step(I_ADDS, 1, 0, 0, 1, 0, BUB,  1, 1, 1, "br.sq1_retake");
        step(I_ADDS, 1, 1, 0, 0, 0, BUB,  0, 1, 1, "br.sq2_stall");
        step(I_ADDS, 1, 0, 0, 0, 0, ADDS, 0, 0, 0, "br.resume");
        step(I_CMP,  1, 0, 1, 0, 0, BUB,  0, 0, 0, "flush_uncounted");

        // Reset mid-squash, then reset coinciding with a taken branch.
        step(I_ADDS, 1, 0, 0, 1, 0, BUB,  1, 1, 1, "rs.taken");
        step(I_ADDS, 1, 0, 0, 0, 1, BUB,  0, 1, 0, "rs.reset");
        step(I_ADDS, 1, 0, 0, 0, 0, ADDS, 0, 0, 0, "rs.after");
        step(I_BEQ,  1, 0, 0, 1, 1, BUB,  0, 1, 0, "rs.reset_bt");
        step(I_CMP,  1, 0, 0, 0, 0, CMP,  0, 0, 0, "rs.after2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
